// File: rtl/conv_sequencer.sv
// conv_sequencer: one FSM that schedules load, P-lane MAC compute, output write and drain for a 1-D convolution frame.
// Optional build macro CONV_SEQ_OVERLAP_LOAD_EN lets the next frame's samples load while the current outputs drain.
module conv_sequencer #(
    parameter int LENX    = 8,
    parameter int LENF    = 4,
    parameter int P       = 2,
    parameter int ADDRX   = 3,
    parameter int ADDRF   = 2,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid_x,
    output logic                   s_ready_x,
    output logic                   x_wr_en,
    output logic [ADDRX-1:0]       x_wr_addr,
    output logic [P*ADDRX-1:0]     x_rd_addr,
    output logic [ADDRF-1:0]       f_rd_addr,
    output logic                   acc_en,
    output logic                   acc_clr,
    output logic                   y_wr_en,
    output logic [ADDRX-1:0]       y_wr_addr,
    output logic [$clog2(P+1)-1:0] y_wr_lanes,
    output logic [ADDRX-1:0]       y_rd_addr,
    output logic                   m_valid_y,
    input  logic                   m_ready_y,
    output logic                   frame_done
);

    localparam int SIZE  = LENX - LENF + 1;
    localparam int LANEW = $clog2(P + 1);
    localparam int CW    = ADDRX + 1;
    localparam int WCW   = $clog2(MEM_LAT + 2);

    localparam logic [CW-1:0]    LENX_C = CW'(LENX);
    localparam logic [CW-1:0]    SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0]    P_C    = CW'(P);
    localparam logic [ADDRF-1:0] K_LAST = ADDRF'(LENF - 1);
    localparam logic [WCW-1:0]   W_LAST = WCW'(MEM_LAT);
    localparam logic [ADDRX-1:0] Y_LAST = ADDRX'(SIZE - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_RD,
        S_VALID
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      load_cnt_q, load_cnt_d;
    logic [CW-1:0]      g_q, g_d;
    logic [ADDRF-1:0]   k_q, k_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [ADDRX-1:0]   y_rd_q, y_rd_d;
    logic [MEM_LAT-1:0] issue_sr_q, issue_sr_d;
    logic [MEM_LAT-1:0] clr_sr_q, clr_sr_d;
    logic               s_ready_q, s_ready_d;
    logic [ADDRF-1:0]   f_rd_q, f_rd_d;
    logic [P*ADDRX-1:0] x_rd_q, x_rd_d;
    logic               y_wr_en_q, y_wr_en_d;
    logic [ADDRX-1:0]   y_wr_addr_q, y_wr_addr_d;
    logic [LANEW-1:0]   y_wr_lanes_q, y_wr_lanes_d;
    logic               m_valid_q, m_valid_d;

    logic accept;
    logic handshake;
    logic last_out;
    int   lane_sum;

    assign accept     = s_valid_x & s_ready_q;
    assign handshake  = m_valid_q & m_ready_y;
    assign last_out   = (y_rd_q == Y_LAST);

    assign s_ready_x  = s_ready_q;
    assign x_wr_en    = accept;
    assign x_wr_addr  = load_cnt_q[ADDRX-1:0];
    assign x_rd_addr  = x_rd_q;
    assign f_rd_addr  = f_rd_q;
    assign acc_en     = issue_sr_q[MEM_LAT-1];
    assign acc_clr    = clr_sr_q[MEM_LAT-1];
    assign y_wr_en    = y_wr_en_q;
    assign y_wr_addr  = y_wr_addr_q;
    assign y_wr_lanes = y_wr_lanes_q;
    assign y_rd_addr  = y_rd_q;
    assign m_valid_y  = m_valid_q;
    assign frame_done = handshake & last_out;

    // Next-state and counter schedule; the output registers below are derived from the next state.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = accept ? load_cnt_q + CW'(1) : load_cnt_q;
        g_d        = g_q;
        k_d        = k_q;
        wait_d     = wait_q;
        y_rd_d     = y_rd_q;

        case (state_q)
            S_LOAD: begin
                if (accept && load_cnt_q == LENX_C - CW'(1)) begin
                    state_d    = S_ISSUE;
                    load_cnt_d = '0;
                    g_d        = '0;
                    k_d        = '0;
                end
            end
            S_ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = S_WAIT;
                    k_d     = '0;
                    wait_d  = '0;
                end else begin
                    k_d = k_q + ADDRF'(1);
                end
            end
            S_WAIT: begin
                if (wait_q == W_LAST) begin
                    state_d = S_WRITE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_WRITE: begin
                if (g_q + P_C >= SIZE_C) begin
                    state_d = S_RD;
                    y_rd_d  = '0;
                end else begin
                    state_d = S_ISSUE;
                    g_d     = g_q + P_C;
                    k_d     = '0;
                end
            end
            S_RD: begin
                state_d = S_VALID;
            end
            S_VALID: begin
                if (handshake) begin
                    if (last_out) begin
                        g_d    = '0;
                        k_d    = '0;
                        y_rd_d = '0;
`ifdef CONV_SEQ_OVERLAP_LOAD_EN
                        // A fully preloaded next frame skips LOAD entirely.
                        if (load_cnt_d == LENX_C) begin
                            state_d    = S_ISSUE;
                            load_cnt_d = '0;
                        end else begin
                            state_d = S_LOAD;
                        end
`else
                        state_d    = S_LOAD;
                        load_cnt_d = '0;
`endif
                    end else begin
                        state_d = S_RD;
                        y_rd_d  = y_rd_q + ADDRX'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_comb begin
        lane_sum   = 0;
        issue_sr_d = '0;
        clr_sr_d   = '0;
        x_rd_d     = '0;

`ifdef CONV_SEQ_OVERLAP_LOAD_EN
        s_ready_d = (state_d == S_LOAD) ||
                    ((state_d == S_RD || state_d == S_VALID) && load_cnt_d < LENX_C);
`else
        s_ready_d = (state_d == S_LOAD);
`endif

        // acc_en/acc_clr trail each issue cycle by exactly MEM_LAT cycles.
        issue_sr_d[0] = (state_q == S_ISSUE);
        clr_sr_d[0]   = (state_q == S_ISSUE) && (k_q == '0);
        for (int j = 1; j < MEM_LAT; j++) begin
            issue_sr_d[j] = issue_sr_q[j-1];
            clr_sr_d[j]   = clr_sr_q[j-1];
        end

        f_rd_d = (state_d == S_ISSUE) ? k_d : '0;
        for (int i = 0; i < P; i++) begin
            lane_sum = int'(g_d) + i + int'(k_d);
            if (lane_sum > LENX - 1) begin
                lane_sum = LENX - 1;
            end
            if (state_d == S_ISSUE) begin
                x_rd_d[i*ADDRX +: ADDRX] = ADDRX'(lane_sum);
            end
        end

        y_wr_en_d    = (state_d == S_WRITE);
        y_wr_addr_d  = (state_d == S_WRITE) ? g_d[ADDRX-1:0] : '0;
        y_wr_lanes_d = '0;
        if (state_d == S_WRITE) begin
            if (SIZE_C - g_d >= P_C) begin
                y_wr_lanes_d = LANEW'(P);
            end else begin
                y_wr_lanes_d = LANEW'(SIZE_C - g_d);
            end
        end

        m_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            load_cnt_q   <= '0;
            g_q          <= '0;
            k_q          <= '0;
            wait_q       <= '0;
            y_rd_q       <= '0;
            issue_sr_q   <= '0;
            clr_sr_q     <= '0;
            s_ready_q    <= 1'b1;
            f_rd_q       <= '0;
            x_rd_q       <= '0;
            y_wr_en_q    <= 1'b0;
            y_wr_addr_q  <= '0;
            y_wr_lanes_q <= '0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            g_q          <= g_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            y_rd_q       <= y_rd_d;
            issue_sr_q   <= issue_sr_d;
            clr_sr_q     <= clr_sr_d;
            s_ready_q    <= s_ready_d;
            f_rd_q       <= f_rd_d;
            x_rd_q       <= x_rd_d;
            y_wr_en_q    <= y_wr_en_d;
            y_wr_addr_q  <= y_wr_addr_d;
            y_wr_lanes_q <= y_wr_lanes_d;
            m_valid_q    <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized frames checked against a per-cycle schedule computed from group timing arithmetic.
module tb_conv_sequencer;

    localparam int LENX    = 8;
    localparam int LENF    = 4;
    localparam int P       = 2;
    localparam int ADDRX   = 3;
    localparam int ADDRF   = 2;
    localparam int MEM_LAT = 1;
    localparam int SIZE    = LENX - LENF + 1;
    localparam int LANEW   = $clog2(P + 1);
    localparam int PER     = LENF + MEM_LAT + 2;
    localparam int NGRP    = (SIZE + P - 1) / P;
    localparam int FULL    = NGRP * PER;
    localparam int RW      = 2 + ADDRX + P*ADDRX + ADDRF + 3 + ADDRX + LANEW + ADDRX + 2;
`ifdef CONV_SEQ_OVERLAP_LOAD_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   s_valid_x;
    logic                   s_ready_x;
    logic                   x_wr_en;
    logic [ADDRX-1:0]       x_wr_addr;
    logic [P*ADDRX-1:0]     x_rd_addr;
    logic [ADDRF-1:0]       f_rd_addr;
    logic                   acc_en;
    logic                   acc_clr;
    logic                   y_wr_en;
    logic [ADDRX-1:0]       y_wr_addr;
    logic [LANEW-1:0]       y_wr_lanes;
    logic [ADDRX-1:0]       y_rd_addr;
    logic                   m_valid_y;
    logic                   m_ready_y;
    logic                   frame_done;

    int checks;
    int errors;

    conv_sequencer #(
        .LENX(LENX), .LENF(LENF), .P(P), .ADDRX(ADDRX), .ADDRF(ADDRF), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_rd_addr(x_rd_addr),
        .f_rd_addr(f_rd_addr), .acc_en(acc_en), .acc_clr(acc_clr),
        .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_wr_lanes(y_wr_lanes),
        .y_rd_addr(y_rd_addr), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One synchronous reset cycle, then every output must be zero except s_ready_x.
    task automatic test_reset();
        logic [RW-1:0] obs;
        logic [RW-1:0] expv;
        @(negedge clk);
        reset = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        obs = {s_ready_x, x_wr_en, x_wr_addr, x_rd_addr, f_rd_addr, acc_en, acc_clr,
               y_wr_en, y_wr_addr, y_wr_lanes, y_rd_addr, m_valid_y, frame_done};
        expv = '0;
        expv[RW-1] = 1'b1;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, expv);
        end
    endtask

    // Stream LENX samples (optionally with random gaps) starting at load count 'start'.
    task automatic test_load(input bit b2b, input int start);
        int cnt;
        int cyc;
        cnt = start;
        cyc = 0;
        while (cnt < LENX && cyc < 200) begin
            @(negedge clk);
            s_valid_x = b2b ? 1'b1 : 1'(($urandom % 3) != 0);
            m_ready_y = 1'($urandom % 2);
            #1;
            checks++;
            if (s_ready_x !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_ready: got %0d expected 1 (sample %0d)", s_ready_x, cnt);
            end
            checks++;
            if (x_wr_en !== s_valid_x) begin
                errors++;
                $display("[TB] FAIL load_wr_en: got %0d expected %0d", x_wr_en, s_valid_x);
            end
            if (s_valid_x) begin
                checks++;
                if (x_wr_addr !== ADDRX'(cnt)) begin
                    errors++;
                    $display("[TB] FAIL load_wr_addr: got %0d expected %0d", x_wr_addr, cnt);
                end
                cnt++;
            end
            cyc++;
        end
        checks++;
        if (cnt < LENX) begin
            errors++;
            $display("[TB] FAIL load_timeout: got %0d samples expected %0d", cnt, LENX);
        end
    endtask

    // Compute phase: group j occupies cycles j*PER..j*PER+PER-1 after the last load accept.
    task automatic test_compute(input int stop_rel);
        for (int rel = 0; rel < stop_rel; rel++) begin
            int j;
            int ph;
            int g;
            int a;
            int lanes;
            bit exp_acc;
            bit exp_clr;
            @(negedge clk);
            s_valid_x = 1'($urandom % 2);
            m_ready_y = 1'($urandom % 2);
            #1;
            j = rel / PER;
            ph = rel % PER;
            g = j * P;
            a = ph - MEM_LAT;
            exp_acc = (a >= 0) && (a < LENF);
            exp_clr = (a == 0);
            checks++;
            if (s_ready_x !== 1'b0 || x_wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL compute_no_load: got ready=%0d wr=%0d expected 0/0 at cycle %0d",
                         s_ready_x, x_wr_en, rel);
            end
            checks++;
            if (m_valid_y !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL compute_no_out: got valid=%0d done=%0d expected 0/0 at cycle %0d",
                         m_valid_y, frame_done, rel);
            end
            if (ph < LENF) begin
                checks++;
                if (f_rd_addr !== ADDRF'(ph)) begin
                    errors++;
                    $display("[TB] FAIL f_rd_addr: got %0d expected %0d at cycle %0d", f_rd_addr, ph, rel);
                end
                for (int i = 0; i < P; i++) begin
                    int e;
                    e = g + i + ph;
                    if (e > LENX - 1) e = LENX - 1;
                    checks++;
                    if (x_rd_addr[i*ADDRX +: ADDRX] !== ADDRX'(e)) begin
                        errors++;
                        $display("[TB] FAIL lane%0d_addr: got %0d expected %0d at cycle %0d",
                                 i, x_rd_addr[i*ADDRX +: ADDRX], e, rel);
                    end
                end
            end
            checks++;
            if (acc_en !== exp_acc || acc_clr !== exp_clr) begin
                errors++;
                $display("[TB] FAIL acc_ctrl: got en=%0d clr=%0d expected %0d/%0d at cycle %0d",
                         acc_en, acc_clr, exp_acc, exp_clr, rel);
            end
            checks++;
            if (y_wr_en !== (ph == PER - 1)) begin
                errors++;
                $display("[TB] FAIL y_wr_en: got %0d expected %0d at cycle %0d", y_wr_en, ph == PER - 1, rel);
            end
            if (ph == PER - 1) begin
                lanes = (SIZE - g < P) ? SIZE - g : P;
                checks++;
                if (y_wr_addr !== ADDRX'(g) || y_wr_lanes !== LANEW'(lanes)) begin
                    errors++;
                    $display("[TB] FAIL y_write: got addr=%0d lanes=%0d expected %0d/%0d",
                             y_wr_addr, y_wr_lanes, g, lanes);
                end
            end
        end
    endtask

    // Drain SIZE outputs; each handshake is followed by one read-latency cycle without valid.
    task automatic test_drain(input int stall_at, input bit rand_ready, input int offer, output int accepted);
        int hs;
        int stall;
        int cyc;
        bit rd;
        bit done;
        bit fire;
        bit exp_ready;
        hs = 0;
        stall = 0;
        cyc = 0;
        rd = 1'b1;
        done = 1'b0;
        accepted = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (stall_at == hs && stall < 10) m_ready_y = 1'b0;
            else if (rand_ready) m_ready_y = 1'($urandom % 2);
            else m_ready_y = 1'b1;
            s_valid_x = (accepted < offer);
            #1;
            exp_ready = OVL && (accepted < LENX);
            fire = !rd && m_ready_y;
            checks++;
            if (m_valid_y !== !rd) begin
                errors++;
                $display("[TB] FAIL drain_valid: got %0d expected %0d (output %0d)", m_valid_y, !rd, hs);
            end
            checks++;
            if (y_rd_addr !== ADDRX'(hs)) begin
                errors++;
                $display("[TB] FAIL drain_rd_addr: got %0d expected %0d", y_rd_addr, hs);
            end
            checks++;
            if (frame_done !== (fire && hs == SIZE - 1)) begin
                errors++;
                $display("[TB] FAIL frame_done: got %0d expected %0d (output %0d)",
                         frame_done, fire && hs == SIZE - 1, hs);
            end
            checks++;
            if (s_ready_x !== exp_ready || x_wr_en !== (s_valid_x && exp_ready)) begin
                errors++;
                $display("[TB] FAIL drain_load: got ready=%0d wr=%0d expected %0d/%0d",
                         s_ready_x, x_wr_en, exp_ready, s_valid_x && exp_ready);
            end
            if (s_valid_x && exp_ready) begin
                checks++;
                if (x_wr_addr !== ADDRX'(accepted)) begin
                    errors++;
                    $display("[TB] FAIL drain_wr_addr: got %0d expected %0d", x_wr_addr, accepted);
                end
                accepted++;
            end
            if (!rd && !m_ready_y && stall_at == hs) stall++;
            if (fire) begin
                hs++;
                rd = 1'b1;
                if (hs == SIZE) done = 1'b1;
            end else begin
                rd = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d outputs expected %0d", hs, SIZE);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        test_load(1'b1, 0);
        test_compute(FULL);
        test_drain(-1, 1'b0, OVL ? 0 : LENX, acc);
    endtask

    task automatic test_random_frame();
        int acc;
        test_load(1'b0, 0);
        test_compute(FULL);
        test_drain(-1, 1'b1, 0, acc);
    endtask

    task automatic test_stall();
        int acc;
        test_load(1'b0, 0);
        test_compute(FULL);
        test_drain(2, 1'b0, 0, acc);
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        test_load(1'b1, 0);
        test_compute(PER + 2);
        test_reset();
        test_load(1'b0, 0);
        test_compute(FULL);
        test_drain(-1, 1'b1, 0, acc);
    endtask

`ifdef CONV_SEQ_OVERLAP_LOAD_EN
    task automatic test_overlap_load();
        int acc;
        test_load(1'b1, 0);
        test_compute(FULL);
        test_drain(-1, 1'b0, LENX, acc);
        checks++;
        if (acc != LENX) begin
            errors++;
            $display("[TB] FAIL overlap_full: got %0d samples expected %0d", acc, LENX);
        end
        test_compute(FULL);
        test_drain(-1, 1'b1, 3, acc);
        checks++;
        if (acc != 3) begin
            errors++;
            $display("[TB] FAIL overlap_partial: got %0d samples expected 3", acc);
        end
        test_load(1'b0, 3);
        test_compute(FULL);
        test_drain(-1, 1'b1, 0, acc);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        test_reset();
        test_back_to_back();
        test_random_frame();
        test_stall();
        test_reset_mid_frame();
        for (int f = 0; f < 3; f++) test_random_frame();
`ifdef CONV_SEQ_OVERLAP_LOAD_EN
        test_overlap_load();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
